// File: rtl/skintone_pixel_feeder_pkg.sv
// ---------------------------------------------------------------------------
// skintone_pixel_feeder_pkg
// Shared widths, defaults, FSM state encoding and small helpers for the
// skin-tone pixel feeder and its byte unpacker.
// ---------------------------------------------------------------------------
package skintone_pixel_feeder_pkg;

    localparam int PIXEL_W         = 24;   // {Y,Cb,Cr}
    localparam int WORD_W          = 32;   // input stream word
    localparam int FLEN_W          = 16;   // frame length in pixels
    localparam int BREM_W          = 18;   // 3 * frame length in bytes
    localparam int BUF_BYTES       = 6;    // byte buffer depth
    localparam int BCNT_W          = 3;    // holds 0..6
    localparam int DEFAULT_CREDITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_e;

    // Bytes in a frame: 3 * pixels, computed as n + 2n to avoid a multiplier.
    function automatic logic [BREM_W-1:0] frame_bytes(input logic [FLEN_W-1:0] n);
        return {2'b00, n} + {1'b0, n, 1'b0};
    endfunction

endpackage

// File: rtl/skintone_byte_unpacker.sv
// ---------------------------------------------------------------------------
// skintone_byte_unpacker
// Collects little-endian 32-bit words into a 6-byte buffer and slices every
// three consecutive bytes into one 24-bit pixel (first byte -> pixel[7:0]).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   accept           a word is transferred this cycle (caller guarantees
//                    byte_count < 3)
//   emit             pop three bytes as one pixel (caller guarantees
//                    byte_count >= 3); never asserted together with accept
//   flush            last pixel of the frame: drop leftover pad bytes
//   word_in          incoming word
//   byte_count       buffered bytes now
//   byte_count_next  buffered bytes after this edge
//   pixel/pixel_valid registered pixel, valid one cycle per emit
// ---------------------------------------------------------------------------
module skintone_byte_unpacker
    import skintone_pixel_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic                emit,
    input  logic                flush,
    input  logic [WORD_W-1:0]   word_in,
    output logic [BCNT_W-1:0]   byte_count,
    output logic [BCNT_W-1:0]   byte_count_next,
    output logic [PIXEL_W-1:0]  pixel,
    output logic                pixel_valid
);

    logic [BUF_BYTES*8-1:0] buf_q;
    logic [BUF_BYTES*8-1:0] buf_d;
    logic [BCNT_W-1:0]      count_q;
    logic [BCNT_W-1:0]      count_d;
    logic [PIXEL_W-1:0]     pix_q;
    logic [PIXEL_W-1:0]     pix_d;
    logic                   pix_valid_q;
    logic                   pix_valid_d;

    // Next buffer contents, byte count and pixel slice.
    always_comb begin
        pix_valid_d = emit;
        pix_d       = emit ? buf_q[PIXEL_W-1:0] : pix_q;
        buf_d       = buf_q;
        count_d     = count_q;

        if (flush) begin
            // Last pixel taken: whatever remains is pad from the final word.
            buf_d   = {(BUF_BYTES*8){1'b0}};
            count_d = 3'd0;
        end else if (emit) begin
            buf_d   = {24'd0, buf_q[BUF_BYTES*8-1:24]};
            count_d = count_q - 3'd3;
        end else if (accept) begin
            // Append the word right behind the bytes already held.
            case (count_q)
                3'd0:    buf_d[31:0]  = word_in;
                3'd1:    buf_d[39:8]  = word_in;
                3'd2:    buf_d[47:16] = word_in;
                default: buf_d        = buf_q;
            endcase
            count_d = count_q + 3'd4;
        end else begin
            buf_d   = buf_q;
            count_d = count_q;
        end
    end

    // Buffer and pixel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= {(BUF_BYTES*8){1'b0}};
            count_q     <= 3'd0;
            pix_q       <= {PIXEL_W{1'b0}};
            pix_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            count_q     <= count_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign byte_count      = count_q;
    assign byte_count_next = count_d;
    assign pixel           = pix_q;
    assign pixel_valid     = pix_valid_q;

endmodule

// File: rtl/skintone_pixel_feeder.sv
// ---------------------------------------------------------------------------
// skintone_pixel_feeder
// Feeds a frame of packed YCbCr bytes to a pixel datapath, one 24-bit pixel
// at a time, limited by a credit count covering the datapath and the
// downstream result buffer.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, frame_len     frame start pulse and pixel count (sampled in IDLE)
//   word_in/_valid/_ready input word stream handshake
//   pixel_dataout/_valid registered pixel output, one-cycle valid per pixel
//   result_return        consumer popped one result (returns a credit)
//   busy                 frame in RUN or DRAIN
//   done                 one-cycle pulse when all credits are back
//   credit_err           sticky: a credit returned while credits were full
// ---------------------------------------------------------------------------
module skintone_pixel_feeder
    import skintone_pixel_feeder_pkg::*;
#(
    parameter int CREDITS = DEFAULT_CREDITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FLEN_W-1:0]   frame_len,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                word_in_valid,
    output logic                word_in_ready,
    output logic [PIXEL_W-1:0]  pixel_dataout,
    output logic                pixel_dataout_valid,
    input  logic                result_return,
    output logic                busy,
    output logic                done,
    output logic                credit_err
);

    localparam int                CRED_W    = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);
    localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
    localparam logic [CRED_W-1:0] CRED_ZERO = CRED_W'(0);

    feeder_state_e       state_q, state_d;
    logic [FLEN_W-1:0]   pix_rem_q, pix_rem_d;
    logic [BREM_W-1:0]   bytes_rem_q, bytes_rem_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic                credit_err_q, credit_err_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic [PIXEL_W-1:0]  pix_out_q, pix_out_d;
    logic                pix_out_valid_q, pix_out_valid_d;

    logic                accept_s;
    logic                emit_s;
    logic                flush_s;
    logic                ret_full_s;
    logic                ret_ok_s;
    logic [BCNT_W-1:0]   byte_count_s;
    logic [BCNT_W-1:0]   byte_count_next_s;
    logic [PIXEL_W-1:0]  unpk_pixel_s;
    logic                unpk_valid_s;

    skintone_byte_unpacker u_unpacker (
        .clk             (clk),
        .rst             (rst),
        .accept          (accept_s),
        .emit            (emit_s),
        .flush           (flush_s),
        .word_in         (word_in),
        .byte_count      (byte_count_s),
        .byte_count_next (byte_count_next_s),
        .pixel           (unpk_pixel_s),
        .pixel_valid     (unpk_valid_s)
    );

    // Handshake, emission and credit-return qualifiers.
    always_comb begin
        accept_s   = word_in_valid && ready_q;
        emit_s     = (state_q == ST_RUN) && (byte_count_s >= 3'd3) &&
                     (credits_q != CRED_ZERO) && (pix_rem_q != {FLEN_W{1'b0}});
        flush_s    = emit_s && (pix_rem_q == 16'd1);
        ret_full_s = result_return && (credits_q == CRED_FULL);
        ret_ok_s   = result_return && (credits_q != CRED_FULL);
    end

    // Credit counter: emit takes one, a valid return gives one back.
    always_comb begin
        credits_d = credits_q;
        case ({emit_s, ret_ok_s})
            2'b10:   credits_d = credits_q - CRED_ONE;
            2'b01:   credits_d = credits_q + CRED_ONE;
            default: credits_d = credits_q;
        endcase
    end

    // Frame FSM, remaining-work counters and status flags.
    always_comb begin
        state_d      = state_q;
        pix_rem_d    = pix_rem_q;
        bytes_rem_d  = bytes_rem_q;
        done_d       = 1'b0;
        credit_err_d = credit_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pix_rem_d    = frame_len;
                    bytes_rem_d  = frame_bytes(frame_len);
                    credit_err_d = 1'b0;
                    state_d      = (frame_len == 16'd0) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (emit_s) begin
                    pix_rem_d = pix_rem_q - 16'd1;
                end else begin
                    pix_rem_d = pix_rem_q;
                end
                if (accept_s) begin
                    // The last word may carry pad bytes past the frame end.
                    bytes_rem_d = (bytes_rem_q > 18'd4) ? (bytes_rem_q - 18'd4) : 18'd0;
                end else begin
                    bytes_rem_d = bytes_rem_q;
                end
                if (pix_rem_q == 16'd0) begin
                    state_d     = ST_DRAIN;
                    bytes_rem_d = 18'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (credits_q == CRED_FULL) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pix_rem_d   = 16'd0;
                bytes_rem_d = 18'd0;
            end
        endcase

        // A stray return is flagged even in the cycle a start clears the flag.
        if (ret_full_s) begin
            credit_err_d = 1'b1;
        end else begin
            credit_err_d = credit_err_d;
        end
    end

    // Registered ready is computed from next-cycle state so it is exact.
    always_comb begin
        ready_d = (state_d == ST_RUN) && (byte_count_next_s < 3'd3) &&
                  (bytes_rem_d != 18'd0);
    end

    // Output pixel stage: second register after the unpacker slice.
    always_comb begin
        pix_out_valid_d = unpk_valid_s;
        if (unpk_valid_s) begin
            pix_out_d = unpk_pixel_s;
        end else begin
            pix_out_d = pix_out_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pix_rem_q       <= 16'd0;
            bytes_rem_q     <= 18'd0;
            credits_q       <= CRED_FULL;
            credit_err_q    <= 1'b0;
            done_q          <= 1'b0;
            ready_q         <= 1'b0;
            pix_out_q       <= {PIXEL_W{1'b0}};
            pix_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pix_rem_q       <= pix_rem_d;
            bytes_rem_q     <= bytes_rem_d;
            credits_q       <= credits_d;
            credit_err_q    <= credit_err_d;
            done_q          <= done_d;
            ready_q         <= ready_d;
            pix_out_q       <= pix_out_d;
            pix_out_valid_q <= pix_out_valid_d;
        end
    end

    assign word_in_ready       = ready_q;
    assign pixel_dataout       = pix_out_q;
    assign pixel_dataout_valid = pix_out_valid_q;
    assign busy                = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done                = done_q;
    assign credit_err          = credit_err_q;

endmodule

// File: tb/tb_skintone_pixel_feeder.sv
module tb_skintone_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic [31:0] word_in;
    logic        word_in_valid;
    logic        result_return;

    logic        rdy1, pv1, busy1, done1, err1;
    logic [23:0] pix1;
    logic        rdy2, pv2, busy2, done2, err2;
    logic [23:0] pix2;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;

    // bench state shared between the stream process and the tests
    logic [31:0] wq[$];
    logic [23:0] got[$];
    int          ret_q[$];
    int          sel = 0;
    bit          auto_ret = 1'b0;
    int          man_ret = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          first_acc_cyc = 0;
    int          first_pix_cyc = 0;
    bit          xfer_pend = 1'b0;

    skintone_pixel_feeder dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(rdy1),
        .pixel_dataout(pix1), .pixel_dataout_valid(pv1),
        .result_return(result_return), .busy(busy1), .done(done1), .credit_err(err1)
    );

    skintone_pixel_feeder #(.CREDITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(rdy2),
        .pixel_dataout(pix2), .pixel_dataout_valid(pv2),
        .result_return(result_return), .busy(busy2), .done(done2), .credit_err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word source, pixel/done monitor and result-return driver, all on negedge.
    initial begin
        word_in       = 32'd0;
        word_in_valid = 1'b0;
        result_return = 1'b0;
        forever begin
            @(negedge clk);
            if (xfer_pend) begin
                if (wq.size() > 0) wq.delete(0);
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
            if (wq.size() > 0) begin
                word_in       = wq[0];
                word_in_valid = 1'b1;
            end else begin
                word_in_valid = 1'b0;
            end
            xfer_pend = word_in_valid && ((sel != 0) ? rdy2 : rdy1);

            if ((sel != 0) ? pv2 : pv1) begin
                got.push_back((sel != 0) ? pix2 : pix1);
                if (got.size() == 1) first_pix_cyc = cyc;
                if (auto_ret) ret_q.push_back(cyc + 16);
            end
            if ((sel != 0) ? done2 : done1) done_cnt++;

            result_return = 1'b0;
            if (man_ret > 0) begin
                result_return = 1'b1;
                man_ret--;
            end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                result_return = 1'b1;
                ret_q.delete(0);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wq.delete();
        ret_q.delete();
        man_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        acc_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] n);
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) break;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy1, 1'b0);
        chk("rst_pix", pix1, 24'd0);
        chk("rst_valid", pv1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_err", err1, 1'b0);
        chk("rst2_ready", rdy2, 1'b0);
        chk("rst2_busy", busy2, 1'b0);
        rst = 1'b0;

        // four-pixel frame, returns 16 cycles after each pixel
        apply_reset();
        sel = 0; auto_ret = 1'b1;
        wq.push_back(32'h44332211);
        wq.push_back(32'h88776655);
        wq.push_back(32'hCCBBAA99);
        do_start(16'd4);
        start = 1'b1; frame_len = 16'd1;  // ignored: not in IDLE
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300);
        repeat (4) @(posedge clk);
        #1;
        chk("f4_npix", got.size(), 4);
        chk("f4_pix0", (got.size() > 0) ? got[0] : 24'hx, 24'h332211);
        chk("f4_pix1", (got.size() > 1) ? got[1] : 24'hx, 24'h665544);
        chk("f4_pix2", (got.size() > 2) ? got[2] : 24'hx, 24'h998877);
        chk("f4_pix3", (got.size() > 3) ? got[3] : 24'hx, 24'hCCBBAA);
        chk("f4_latency", first_pix_cyc - first_acc_cyc, 2);
        chk("f4_words", acc_cnt, 3);
        chk("f4_done", done_cnt, 1);
        chk("f4_busy", busy1, 1'b0);

        // one-pixel frame, pad byte discarded, one word only
        apply_reset();
        sel = 0; auto_ret = 1'b1;
        wq.push_back(32'hDDCCBBAA);
        wq.push_back(32'h11111111);
        do_start(16'd1);
        wait_done(200);
        repeat (4) @(posedge clk);
        #1;
        chk("f1_npix", got.size(), 1);
        chk("f1_pix0", (got.size() > 0) ? got[0] : 24'hx, 24'hCCBBAA);
        chk("f1_words", acc_cnt, 1);
        chk("f1_done", done_cnt, 1);

        // CREDITS=2 instance: stall after 2 pixels, one more per return
        apply_reset();
        sel = 1; auto_ret = 1'b0;
        for (int i = 0; i < 6; i++) wq.push_back(32'h10203040 + i);
        do_start(16'd8);
        repeat (40) @(posedge clk);
        #1;
        chk("cr2_stall_npix", got.size(), 2);
        man_ret = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("cr2_ret_npix", got.size(), 3);
        chk("cr2_words", acc_cnt, 3);
        chk("cr2_busy", busy2, 1'b1);
        sel = 0;

        // zero-length frame
        apply_reset();
        wq.push_back(32'h55555555);
        do_start(16'd0);
        chk("z_ready0", rdy1, 1'b0);
        chk("z_busy", busy1, 1'b1);
        chk("z_done_early", done1, 1'b0);
        @(posedge clk); #1;
        chk("z_done", done1, 1'b1);
        chk("z_ready1", rdy1, 1'b0);
        @(posedge clk); #1;
        chk("z_words", acc_cnt, 0);

        // stray return while credits full, then start clears the flag
        apply_reset();
        man_ret = 1;
        @(posedge clk); #1;
        chk("ce_set", err1, 1'b1);
        do_start(16'd0);
        chk("ce_clear", err1, 1'b0);
        @(posedge clk); #1;
        chk("ce_done_full", done1, 1'b1);

        // reset in the middle of a frame
        apply_reset();
        sel = 0; auto_ret = 1'b0;
        wq.push_back(32'h44332211);
        wq.push_back(32'h88776655);
        wq.push_back(32'hCCBBAA99);
        do_start(16'd4);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (got.size() >= 2) break;
        end
        chk("mr_two_pix", got.size() >= 2, 1'b1);
        rst = 1'b1;
        wq.delete();
        @(posedge clk); #1;
        chk("mr_ready", rdy1, 1'b0);
        chk("mr_pix", pix1, 24'd0);
        chk("mr_valid", pv1, 1'b0);
        chk("mr_busy", busy1, 1'b0);
        chk("mr_done", done1, 1'b0);
        chk("mr_err", err1, 1'b0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mr_no_done", done_cnt, 0);
        got.delete();
        acc_cnt = 0;
        auto_ret = 1'b1;
        wq.push_back(32'h77665544);
        do_start(16'd1);
        wait_done(200);
        #1;
        chk("mr_new_npix", got.size(), 1);
        chk("mr_new_pix", (got.size() > 0) ? got[0] : 24'hx, 24'h665544);
        chk("mr_new_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
